// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: HI/LO busy-window sequencer driving fetch/decode stall and execute flush (optional MD_STALL_CNT_EN adds stall_cnt)
module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic        div_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        done,
    output logic        md_err
`ifdef MD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stall;
    assign busy = (state == BUSY);
    // sequencer: count the busy window, pulse done on exit, flag overlapping issues
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            md_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start_E) begin
                    state <= BUSY;
                    cnt   <= div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end else begin
                cnt <= cnt - 1'b1;
                if (start_E) md_err <= 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end
    // stall when the decode instruction touches HI/LO while a result is pending
    always_comb begin
        stall   = md_use_D & (start_E | busy);
        stall_F = stall;
        stall_D = stall;
        flush_E = stall;
    end
`ifdef MD_STALL_CNT_EN
    // free-running count of stalled cycles, wrapping at 32 bits
    always_ff @(posedge clk) begin
        if (reset) stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb_md_stall_ctrl: scoreboard bench for md_stall_ctrl with a cycle-timestamp reference model
module tb_md_stall_ctrl;
    logic clk = 1'b0, reset = 1'b0, start_E = 1'b0, div_E = 1'b0, md_use_D = 1'b0;
    logic busy, stall_F, stall_D, flush_E, done, md_err;
`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    md_stall_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .div_E    (div_E),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_F  (stall_F),
        .stall_D  (stall_D),
        .flush_E  (flush_E),
        .done     (done),
        .md_err   (md_err)
`ifdef MD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        busy;
        logic        stall;
        logic        done;
        logic        err;
        logic [31:0] scnt;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          t = 0;
    int          first_busy = 1;
    int          last_busy = 0;
    int          done_cyc = -1;
    bit          err_m = 1'b0;
    bit          known = 1'b0;
    logic [31:0] scnt_m = '0;

    // One clock cycle of stimulus; the model predicts outputs from issue timestamps.
    task automatic cyc(input bit r, input bit s, input bit d, input bit u);
        exp_t e;
        bit   b;
        bit   st;
        @(posedge clk);
        #1;
        reset = r; start_E = s; div_E = d; md_use_D = u;
        b  = (t >= first_busy) && (t <= last_busy);
        st = u && (s || b);
        if (known) begin
            e.cyc = t; e.busy = b; e.stall = st; e.done = (t == done_cyc);
            e.err = err_m; e.scnt = scnt_m;
            q.push_back(e);
        end
        if (r) begin
            first_busy = 1; last_busy = 0; done_cyc = -1;
            err_m = 1'b0; scnt_m = '0; known = 1'b1;
        end else begin
            if (s && b) err_m = 1'b1;
            if (s && !b) begin
                first_busy = t + 1;
                last_busy  = t + (d ? 10 : 5);
                done_cyc   = last_busy + 1;
            end
            if (st) scnt_m = scnt_m + 32'd1;
        end
        t++;
    endtask

    function automatic void chk(input string n, input int c, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", n, c, a, x);
        end
    endfunction

    // monitor: compare DUT outputs mid-cycle against queued expectations
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy", e.cyc, 32'(busy), 32'(e.busy));
            chk("stall_F", e.cyc, 32'(stall_F), 32'(e.stall));
            chk("stall_D", e.cyc, 32'(stall_D), 32'(e.stall));
            chk("flush_E", e.cyc, 32'(flush_E), 32'(e.stall));
            chk("done", e.cyc, 32'(done), 32'(e.done));
            chk("md_err", e.cyc, 32'(md_err), 32'(e.err));
`ifdef MD_STALL_CNT_EN
            chk("stall_cnt", e.cyc, stall_cnt, e.scnt);
`endif
        end
    end

    initial begin
        // reset then idle
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // mult, independent instructions only
        cyc(0, 1, 0, 0);
        repeat (7) cyc(0, 0, 0, 0);
        // div with mflo held in decode
        cyc(0, 1, 1, 1);
        repeat (12) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // div aborted by reset at busy cycle 4
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        repeat (12) cyc(0, 0, 0, 0);
        // mult with a second issue while busy
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (6) cyc(0, 0, 0, 0);
        // issue on the final busy cycle is ignored
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
`ifdef MD_STALL_CNT_EN
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 1);
        repeat (11) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1 force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        scnt_m = 32'hFFFF_FFFF;
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
`endif
        // randomized traffic
        repeat (600) cyc(($urandom % 40) == 0, ($urandom % 4) == 0, $urandom % 2 == 1, $urandom % 2 == 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
